// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : LEGv8 fetch stage - owns the PC, reads instruction
//                     memory, hands {Instruction, Address} to decode.
// Revision 1.0
// ============================================================================
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  Address,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  BranchAddress
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [ADDR_W-1:0]    pc, pc_next;
    logic                 valid_next;
    logic [INSTR_W-1:0]   instr_next;
    logic [ADDR_W-1:0]    addr_next;
    logic [ADDR_W-1:0]    target;
    logic                 unused_ba_lsbs;

    // Redirect targets are forced word-aligned so pc[1:0] stays 00.
    assign target         = {BranchAddress[ADDR_W-1:2], 2'b00};
    assign unused_ba_lsbs = ^BranchAddress[1:0];

    assign imem_req  = rst_n && (state == ST_FETCH) && !PCSrc;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            dec_valid   <= 1'b0;
            Instruction <= '0;
            Address     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            dec_valid   <= valid_next;
            Instruction <= instr_next;
            Address     <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = dec_valid;
        instr_next = Instruction;
        addr_next  = Address;
        case (state)
            ST_FETCH: begin
                if (PCSrc) pc_next = target;
                else       state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (PCSrc) begin
                    pc_next    = target;
                    state_next = imem_rvalid ? ST_FETCH : ST_DRAIN;
                end else if (imem_rvalid) begin
                    instr_next = imem_rdata;
                    addr_next  = pc;
                    pc_next    = pc + ADDR_W'(4);
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A redirect squashes the held instruction even if decode takes it.
                if (PCSrc) begin
                    valid_next = 1'b0;
                    pc_next    = target;
                    state_next = ST_FETCH;
                end else if (dec_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (PCSrc)       pc_next    = target;
                if (imem_rvalid) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : self-checking bench for instruction_fetch.
// Revision 1.0
// ============================================================================
module tb_instruction_fetch;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk, rst_n;
    logic        imem_req, w_imem_req;
    logic [63:0] imem_addr, w_imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid, w_dec_valid, dec_ready;
    logic [31:0] Instruction, w_instr;
    logic [63:0] Address, w_addr;
    logic        PCSrc;
    logic [63:0] BranchAddress;

    logic        mem_rv, inj_rv;
    logic [31:0] mem_rdata;
    logic [63:0] maddr;
    int          cnt, lat;
    int          vectors, miscompares;

    assign imem_rvalid = mem_rv | inj_rv;
    assign imem_rdata  = mem_rdata;

    instruction_fetch #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .Instruction(Instruction), .Address(Address),
        .PCSrc(PCSrc), .BranchAddress(BranchAddress));

    instruction_fetch #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(w_dec_valid),
        .dec_ready(dec_ready), .Instruction(w_instr), .Address(w_addr),
        .PCSrc(PCSrc), .BranchAddress(BranchAddress));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: one response, lat cycles after the request cycle.
    initial begin
        mem_rv = 1'b0; mem_rdata = '0; cnt = 0; maddr = '0;
        forever begin
            @(posedge clk); #1;
            mem_rv = 1'b0;
            if (!rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin mem_rv = 1'b1; mem_rdata = word(maddr); end
            end
            @(negedge clk);
            if (rst_n && imem_req) begin cnt = lat; maddr = imem_addr; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; PCSrc = 1'b0; BranchAddress = '0; dec_ready = 1'b1; inj_rv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PCSrc = 1'b0; BranchAddress = '0; dec_ready = 1'b1; inj_rv = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req); end
        vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", dec_valid); end
        vectors++; if (Instruction !== 32'h0 || Address !== 64'h0) begin miscompares++; $display("FAIL reset_out got %h/%h exp 0/0", Instruction, Address); end
        vectors++; if (imem_addr !== 64'h0 || w_imem_addr !== WRAP_PC) begin miscompares++; $display("FAIL reset_pc got %h/%h exp 0/%h", imem_addr, w_imem_addr, WRAP_PC); end
    endtask

    task automatic test_stream();
        lat = 1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++; if (imem_req !== (c % 3 == 0)) begin miscompares++; $display("FAIL stream_req c=%0d got %b", c, imem_req); end
            if (c % 3 == 0) begin
                vectors++; if (imem_addr !== 64'(4 * (c / 3))) begin miscompares++; $display("FAIL stream_addr c=%0d got %h exp %h", c, imem_addr, 64'(4 * (c / 3))); end
            end
            vectors++; if (dec_valid !== (c % 3 == 2)) begin miscompares++; $display("FAIL stream_valid c=%0d got %b", c, dec_valid); end
            if (c % 3 == 2) begin
                vectors++; if (Address !== 64'(4 * (c / 3)) || Instruction !== word(64'(4 * (c / 3)))) begin
                    miscompares++; $display("FAIL stream_data c=%0d got %h/%h exp %h", c, Address, Instruction, 64'(4 * (c / 3))); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        do_reset();
        dec_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (dec_valid !== 1'b1 || imem_req !== 1'b0 || Address !== 64'h0 || Instruction !== word(64'h0)) begin
                miscompares++; $display("FAIL bp_hold i=%0d got v=%b req=%b %h/%h", i, dec_valid, imem_req, Address, Instruction); end
            tick();
        end
        dec_ready = 1'b1;
        tick();
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h4) begin
            miscompares++; $display("FAIL bp_next got v=%b req=%b addr=%h exp 0/1/4", dec_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        lat = 1;
        do_reset();
        dec_ready = 1'b0;
        tick(); tick();
        PCSrc = 1'b1; BranchAddress = 64'h100;
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b1) begin miscompares++; $display("FAIL rh_before got %b exp 1", dec_valid); end
        tick();
        PCSrc = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            miscompares++; $display("FAIL rh_after got v=%b req=%b addr=%h exp 0/1/100", dec_valid, imem_req, imem_addr); end
        tick(); tick();
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b1 || Address !== 64'h100 || Instruction !== word(64'h100)) begin
            miscompares++; $display("FAIL rh_deliver got v=%b %h/%h exp 1/100", dec_valid, Address, Instruction); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        lat = 4;
        do_reset();
        tick();
        PCSrc = 1'b1; BranchAddress = 64'h203;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL rw_wait got req=%b v=%b exp 0/0", imem_req, dec_valid); end
        tick();
        PCSrc = 1'b0;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL rw_drain c=%0d got req=%b v=%b exp 0/0", c, imem_req, dec_valid); end
            tick();
        end
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin miscompares++; $display("FAIL rw_refetch got req=%b addr=%h exp 1/200", imem_req, imem_addr); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            @(negedge clk);
            if (dec_valid) found = 1'b1;
        end
        vectors++; if (!found || Address !== 64'h200 || Instruction !== word(64'h200)) begin
            miscompares++; $display("FAIL rw_deliver got found=%b %h/%h exp 1/200", found, Address, Instruction); end
    endtask

    task automatic test_simultaneous();
        bit found;
        // Redirect together with the response in WAIT.
        lat = 1;
        do_reset();
        tick();
        PCSrc = 1'b1; BranchAddress = 64'h40;
        @(negedge clk);
        vectors++; if (imem_rvalid !== 1'b1 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL sim_wait got rv=%b v=%b exp 1/0", imem_rvalid, dec_valid); end
        tick();
        PCSrc = 1'b0;
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
            miscompares++; $display("FAIL sim_wait_next got v=%b req=%b addr=%h exp 0/1/40", dec_valid, imem_req, imem_addr); end
        // Redirect in FETCH suppresses the request.
        do_reset();
        PCSrc = 1'b1; BranchAddress = 64'h87;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL sim_fetch_req got %b exp 0", imem_req); end
        tick();
        PCSrc = 1'b0;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 64'h84) begin miscompares++; $display("FAIL sim_fetch_next got req=%b addr=%h exp 1/84", imem_req, imem_addr); end
        // Repeated redirects while draining: the last one wins.
        lat = 6;
        do_reset();
        tick();
        PCSrc = 1'b1; BranchAddress = 64'h300;
        tick();
        BranchAddress = 64'h404;
        tick();
        BranchAddress = 64'h50B;
        tick();
        PCSrc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (imem_req) found = 1'b1;
            else tick();
        end
        vectors++; if (!found || imem_addr !== 64'h508) begin miscompares++; $display("FAIL sim_drain got found=%b addr=%h exp 1/508", found, imem_addr); end
        // Stray response while holding is ignored.
        lat = 1;
        do_reset();
        dec_ready = 1'b0;
        tick(); tick();
        inj_rv = 1'b1;
        tick();
        inj_rv = 1'b0;
        @(negedge clk);
        vectors++; if (dec_valid !== 1'b1 || imem_req !== 1'b0 || Address !== 64'h0 || Instruction !== word(64'h0)) begin
            miscompares++; $display("FAIL sim_stray got v=%b req=%b %h/%h", dec_valid, imem_req, Address, Instruction); end
    endtask

    task automatic test_wrap_and_async_reset();
        lat = 1;
        do_reset();
        @(negedge clk);
        vectors++; if (w_imem_req !== 1'b1 || w_imem_addr !== WRAP_PC) begin miscompares++; $display("FAIL wrap_first got req=%b addr=%h", w_imem_req, w_imem_addr); end
        tick(); tick();
        @(negedge clk);
        vectors++; if (w_dec_valid !== 1'b1 || w_addr !== WRAP_PC) begin miscompares++; $display("FAIL wrap_deliver got v=%b addr=%h", w_dec_valid, w_addr); end
        tick();
        @(negedge clk);
        vectors++; if (w_imem_req !== 1'b1 || w_imem_addr !== 64'h0) begin miscompares++; $display("FAIL wrap_second got req=%b addr=%h exp 1/0", w_imem_req, w_imem_addr); end
        tick();
        vectors++; if (imem_addr !== 64'h4) begin miscompares++; $display("FAIL areset_pre got addr=%h exp 4", imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (imem_addr !== 64'h0 || w_imem_addr !== WRAP_PC || imem_req !== 1'b0) begin
            miscompares++; $display("FAIL areset_pc got %h/%h req=%b", imem_addr, w_imem_addr, imem_req); end
        vectors++; if (dec_valid !== 1'b0 || Instruction !== 32'h0 || Address !== 64'h0) begin
            miscompares++; $display("FAIL areset_out got v=%b %h/%h", dec_valid, Instruction, Address); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit          inflight, held, cancelled, exp_req;
        logic [63:0] exp_next, out_addr, last_addr;
        logic [31:0] last_instr;
        lat = 1;
        do_reset();
        inflight = 0; held = 0; cancelled = 0;
        exp_next = '0; out_addr = '0; last_addr = '0; last_instr = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_req = !inflight && !held && !PCSrc;
            vectors++; if (imem_req !== exp_req) begin miscompares++; $display("FAIL rnd_req c=%0d got %b exp %b", c, imem_req, exp_req); end
            if (exp_req) begin
                vectors++; if (imem_addr !== exp_next) begin miscompares++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, exp_next); end
            end
            vectors++; if (dec_valid !== held) begin miscompares++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, dec_valid, held); end
            vectors++; if (Address !== last_addr || Instruction !== last_instr) begin
                miscompares++; $display("FAIL rnd_data c=%0d got %h/%h exp %h/%h", c, Address, Instruction, last_addr, last_instr); end
            // Transaction-level model of what the clock edge does.
            if (held && (PCSrc || dec_ready)) held = 0;
            if (imem_rvalid && inflight) begin
                if (!cancelled && !PCSrc) begin
                    held = 1; last_addr = out_addr; last_instr = word(out_addr);
                    exp_next = out_addr + 64'd4;
                end
                inflight = 0;
            end
            if (exp_req) begin inflight = 1; out_addr = exp_next; cancelled = 0; end
            if (PCSrc) begin
                exp_next = {BranchAddress[63:2], 2'b00};
                if (inflight) cancelled = 1;
            end
            tick();
            dec_ready = ($urandom % 4) != 0;
            PCSrc = ($urandom % 10) == 0;
            BranchAddress = {$urandom, $urandom};
            if ($urandom % 4 == 0) BranchAddress[63:8] = '1;
            lat = int'($urandom_range(1, 4));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_hold();
        test_redirect_wait();
        test_simultaneous();
        test_wrap_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
